// File: rtl/yarvi_scoreboard.sv
// Register scoreboard for long-latency writes (loads/CSRs): tracks busy
// destinations, gates issue on RAW/WAW/capacity hazards, counts stalls.
module yarvi_scoreboard #(
  parameter int MAX_PENDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_use_rs1,
  input  logic        issue_use_rs2,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        issue_wr,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic [31:0] busy,
  output logic [2:0]  pending,
  output logic [15:0] stall_count,
  output logic        wb_err
);

  localparam logic [2:0] MaxPending = 3'(MAX_PENDING);

  logic [31:0] busy_q, busy_d;
  logic [2:0]  pending_q, pending_d;
  logic [15:0] stall_q, stall_d;
  logic        wbErr_q, wbErr_d;

  logic rawHazard, wrNonZero, wawHazard, capHazard;
  logic doSet, doClr, wbBad;

  // Hazard check sees only registered state, so a writeback cannot release
  // a stalled instruction until the cycle after it completes.
  always_comb begin
    rawHazard   = (issue_use_rs1 && busy_q[issue_rs1]) ||
                  (issue_use_rs2 && busy_q[issue_rs2]);
    wrNonZero   = issue_wr && (issue_rd != 5'd0);
    wawHazard   = wrNonZero && busy_q[issue_rd];
    capHazard   = wrNonZero && (pending_q == MaxPending);
    issue_ready = !flush && !rawHazard && !wawHazard && !capHazard;
  end

  always_comb begin
    doSet     = issue_valid && issue_ready && wrNonZero;
    doClr     = wb_valid && (wb_rd != 5'd0) && busy_q[wb_rd];
    wbBad     = wb_valid && !doClr;

    busy_d    = busy_q;
    pending_d = pending_q;
    stall_d   = stall_q;
    wbErr_d   = wbErr_q || wbBad;

    if (doSet) busy_d[issue_rd] = 1'b1;
    if (doClr) busy_d[wb_rd]    = 1'b0;
    busy_d[0] = 1'b0;

    // Set and clear always target different registers (WAW blocks the same one).
    case ({doSet, doClr})
      2'b10:   pending_d = pending_q + 3'd1;
      2'b01:   pending_d = pending_q - 3'd1;
      default: pending_d = pending_q;
    endcase

    if (flush) begin
      busy_d    = 32'd0;
      pending_d = 3'd0;
    end

    if (issue_valid && !issue_ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q    <= 32'd0;
      pending_q <= 3'd0;
      stall_q   <= 16'd0;
      wbErr_q   <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      stall_q   <= stall_d;
      wbErr_q   <= wbErr_d;
    end
  end

  assign busy        = busy_q;
  assign pending     = pending_q;
  assign stall_count = stall_q;
  assign wb_err      = wbErr_q;

endmodule

// File: doc/yarvi_scoreboard.md
YARVI_SCOREBOARD -- requirements
Module: yarvi_scoreboard

Interface
REQ-001 SHALL have parameter MAX_PENDING, default 4, legal 1..7: maximum long-latency register writes in flight.
REQ-002 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port issue_valid, input, 1: an instruction is presented for issue this cycle.
REQ-005 SHALL have port issue_use_rs1, input, 1: instruction reads rs1 (already 0 when rs1 = x0).
REQ-006 SHALL have port issue_use_rs2, input, 1: instruction reads rs2 (already 0 when rs2 = x0).
REQ-007 SHALL have ports issue_rs1 and issue_rs2, input, 5 each: source register indices.
REQ-008 SHALL have port issue_wr, input, 1: instruction writes rd with long latency (load/CSR).
REQ-009 SHALL have port issue_rd, input, 5: destination index.
REQ-010 SHALL have port issue_ready, output, 1: no hazard; the instruction is accepted when issue_valid && issue_ready.
REQ-011 SHALL have ports wb_valid, input, 1, and wb_rd, input, 5: a long-latency write completes for wb_rd.
REQ-012 SHALL have port flush, input, 1: discard all in-flight tracking.
REQ-013 SHALL have port busy, output, 32: registered busy vector; bit 0 is always 0.
REQ-014 SHALL have port pending, output, 3: count of set busy bits.
REQ-015 SHALL have port stall_count, output, 16: saturating count of cycles with issue_valid && !issue_ready.
REQ-016 SHALL have port wb_err, output, 1: sticky flag for a writeback to a non-busy register or to x0.

Function
REQ-017 issue_ready SHALL be combinational from registered state and the current issue inputs only; it SHALL NOT depend on wb_valid, so there is no writeback bypass.
REQ-018 issue_ready SHALL be 0 on a RAW hazard: (issue_use_rs1 && busy[issue_rs1]) || (issue_use_rs2 && busy[issue_rs2]).
REQ-019 issue_ready SHALL be 0 on a WAW hazard: issue_wr && issue_rd != 0 && busy[issue_rd].
REQ-020 issue_ready SHALL be 0 on capacity: issue_wr && issue_rd != 0 && pending == MAX_PENDING.
REQ-021 issue_ready SHALL be 0 while flush is high; otherwise it is 1.
REQ-022 An accepted issue with issue_wr && issue_rd != 0 SHALL set busy[issue_rd] at the next edge.
REQ-023 An issue with issue_rd == 0 SHALL set nothing.
REQ-024 wb_valid with busy[wb_rd] == 1 SHALL clear busy[wb_rd] at the next edge.
REQ-025 wb_valid with busy[wb_rd] == 0, or with wb_rd == 0, SHALL leave busy unchanged and set wb_err, which holds until reset.
REQ-026 An issue set and a writeback clear of different registers in the same cycle SHALL both take effect, leaving pending unchanged.
REQ-027 A same-register set and clear in one cycle is impossible by REQ-019; no priority is required.
REQ-028 flush SHALL clear busy and pending at the next edge, overriding simultaneous issue and writeback, and SHALL NOT alter wb_err or stall_count.
REQ-029 pending SHALL always equal popcount(busy) and SHALL be maintained as an incrementing/decrementing counter, never exceeding MAX_PENDING.
REQ-030 stall_count SHALL increment by 1 per stalled cycle and saturate at 16'hFFFF.
REQ-031 A cycle in which flush forces issue_ready low SHALL count as a stall when issue_valid = 1.
REQ-032 With issue_valid = 0, issue_ready SHALL still reflect the hazard check but SHALL cause no state change.

Reset
REQ-033 At a reset edge: busy = 0, pending = 0, stall_count = 0, wb_err = 0.
REQ-034 Reset SHALL take priority over flush, issue and writeback in the same cycle.
REQ-035 A reset asserted mid-operation SHALL discard all in-flight tracking; later writebacks for those registers SHALL set wb_err.

Verification
REQ-036 Load-use stall: issue wr rd=5; next cycle, issue use_rs1 rs1=5 -> issue_ready=0 and stall_count increments each cycle. Then wb rd=5 -> issue_ready=1 the cycle after the writeback, not in the same cycle.
REQ-037 WAW and capacity (MAX_PENDING=4): issue wr to rd=1,2,3,4 -> pending=4, busy=32'h1E. A wr to rd=6 -> stalled. A wr to rd=2 -> stalled. A non-writing issue with no busy sources -> ready=1.
REQ-038 Simultaneous events: issue wr rd=7 in the same cycle as wb rd=1 -> pending unchanged, busy[7]=1, busy[1]=0.
REQ-039 Flush: with 3 pending, flush plus an issue wr rd=9 -> issue_ready=0 and next cycle busy=0, pending=0.
REQ-040 Errors: wb rd=0 -> wb_err=1. wb to a non-busy rd=12 -> busy unchanged and wb_err stays 1 until reset. Reset -> all outputs at reset values.
REQ-041 Saturation: hold a stall for 70000 cycles -> stall_count=16'hFFFF.
